imem_ctrl: RTL and testbench

Instruction-memory responder for the core's fetch stage. Each cycle it takes the fetch stage's `next_pc`, issues a single-outstanding request on the instruction bus, and returns `instr_read_data` with a one-cycle `instr_read_data_valid` strobe for the address the fetch stage currently holds in `pc`. Responses for addresses the fetch stage has already left (jump, branch, trap, mret) are dropped. It sits between `fetch` and the instruction bus or ITCM port.

---
 rtl/imem_ctrl_if.sv | 22 ++
 rtl/imem_ctrl.sv | 113 +++++++++++
 tb/tb_imem_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_ctrl_if.sv
// imem_ctrl_if: instruction bus between imem_ctrl (master) and the memory/ITCM port (slave).
// Single outstanding request: req/addr/gnt issue phase, rvalid/rdata response phase.
interface imem_ctrl_if;
  localparam int ADDR_WIDTH  = 32;
  localparam int INSTR_WIDTH = 32;

  logic                   imem_req;
  logic [ADDR_WIDTH-1:0]  imem_addr;
  logic                   imem_gnt;
  logic                   imem_rvalid;
  logic [INSTR_WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/imem_ctrl.sv
// imem_ctrl: fetch-side instruction memory responder, one outstanding bus request at a time.
// Optional one-entry last-fetch buffer compiled in with `define KRV_IMEM_LAST_BUF_EN.
//
// state | meaning
// IDLE  | no request in flight; issue next_pc when out of reset
// REQ   | request posted but not yet granted; address held in r_req_addr
// WAIT  | granted, waiting for rvalid; rvalid cycle is also an issue point
module imem_ctrl (
  input  logic               cpu_clk,
  input  logic               cpu_rstn,
  input  logic [31:0]        boot_addr,
  input  logic [31:0]        next_pc,
  input  logic               imem_buf_inv,
  output logic               instr_read_data_valid,
  output logic [31:0]        instr_read_data,
  imem_ctrl_if.master        imem
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_req_addr;
  logic        r_rst_done;
  logic        w_issue_pt;
  logic        w_issue;
  logic        w_hit;
  logic        w_bus_vld;

  assign w_issue_pt = (r_state == IDLE) || ((r_state == WAIT) && imem.imem_rvalid);
  assign w_issue    = w_issue_pt && r_rst_done && !w_hit;
  // Responses for an address the fetch stage has already left are consumed silently.
  assign w_bus_vld  = imem.imem_rvalid && (r_state == WAIT) && (r_req_addr == r_pc);

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      r_state    <= IDLE;
      r_pc       <= boot_addr;
      r_req_addr <= '0;
      r_rst_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= next_pc;
      r_rst_done <= 1'b1;
      if (w_issue) r_req_addr <= next_pc;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    imem.imem_req  = 1'b0;
    imem.imem_addr = next_pc;
    case (r_state)
      REQ: begin
        imem.imem_req  = 1'b1;
        imem.imem_addr = r_req_addr;
        if (imem.imem_gnt) w_state_nxt = WAIT;
      end
      default: begin
        if (w_issue_pt) begin
          imem.imem_req = w_issue;
          if (!w_issue)           w_state_nxt = IDLE;
          else if (imem.imem_gnt) w_state_nxt = WAIT;
          else                    w_state_nxt = REQ;
        end
      end
    endcase
  end

`ifdef KRV_IMEM_LAST_BUF_EN
  logic        r_buf_vld;
  logic [31:0] r_buf_addr;
  logic [31:0] r_buf_data;
  logic        r_hit;

  assign w_hit = r_buf_vld && (next_pc == r_buf_addr) && !imem_buf_inv;

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      r_buf_vld  <= 1'b0;
      r_buf_addr <= '0;
      r_buf_data <= '0;
      r_hit      <= 1'b0;
    end else begin
      r_hit <= w_issue_pt && r_rst_done && w_hit;
      // Fence invalidation wins over a capture in the same cycle.
      if (imem_buf_inv) begin
        r_buf_vld <= 1'b0;
      end else if (instr_read_data_valid) begin
        r_buf_vld  <= 1'b1;
        r_buf_addr <= r_pc;
        r_buf_data <= instr_read_data;
      end
    end
  end

  assign instr_read_data_valid = w_bus_vld || r_hit;
  assign instr_read_data       = w_bus_vld ? imem.imem_rdata : (r_hit ? r_buf_data : '0);
`else
  logic w_unused_inv;

  assign w_unused_inv          = imem_buf_inv;
  assign w_hit                 = 1'b0;
  assign instr_read_data_valid = w_bus_vld;
  assign instr_read_data       = w_bus_vld ? imem.imem_rdata : '0;
`endif

endmodule

// File: tb/tb_imem_ctrl.sv
// tb_imem_ctrl: directed and randomized fetch traffic against a transaction-level model of imem_ctrl.
// Honours `define KRV_IMEM_LAST_BUF_EN to model and exercise the last-fetch buffer.
`timescale 1ns/1ps
module tb_imem_ctrl;
  logic        cpu_clk = 1'b0;
  logic        cpu_rstn;
  logic [31:0] boot_addr;
  logic [31:0] next_pc;
  logic        imem_buf_inv;
  logic        instr_read_data_valid;
  logic [31:0] instr_read_data;

  imem_ctrl_if bus ();

  imem_ctrl dut (
    .cpu_clk               (cpu_clk),
    .cpu_rstn              (cpu_rstn),
    .boot_addr             (boot_addr),
    .next_pc               (next_pc),
    .imem_buf_inv          (imem_buf_inv),
    .instr_read_data_valid (instr_read_data_valid),
    .instr_read_data       (instr_read_data),
    .imem                  (bus)
  );

  always #5 cpu_clk = ~cpu_clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // transaction-level model: pending (ungranted) / outstanding (granted) request
  logic        m_rst_done, m_pend, m_out, m_hit;
  logic [31:0] m_pc, m_addr;
  logic        m_buf_vld;
  logic [31:0] m_buf_addr, m_buf_data;

  // memory responder
  logic        rs_out;
  int          rs_cnt, rs_wait;
  logic [31:0] rs_addr;
  logic        rnd;
  int          gnt_dly, lat;

  logic        s_req, s_valid;
  logic [31:0] s_addr, s_data;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_rst_done = 1'b0;
    m_pend     = 1'b0;
    m_out      = 1'b0;
    m_hit      = 1'b0;
    m_pc       = boot_addr;
    m_addr     = '0;
    m_buf_vld  = 1'b0;
    m_buf_addr = '0;
    m_buf_data = '0;
  endtask

  task automatic cycle(input logic [31:0] npc, input logic inv, input logic rstn);
    logic        rv, g, free, hit, exp_vbus, exp_req, exp_valid;
    logic [31:0] rd, exp_addr, exp_data;
    @(negedge cpu_clk);
    cpu_rstn = rstn;
    if (!rstn) model_reset();
    next_pc      = npc;
    imem_buf_inv = inv;
    rv = rs_out && (rs_cnt == 0);
    rd = rv ? memf(rs_addr) : $urandom;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rd;
    bus.imem_gnt    = 1'b0;
    #1;
    g = 1'b0;
    if (bus.imem_req && (!rs_out || rv))
      g = rnd ? ($urandom_range(0, 2) != 0) : (rs_wait >= gnt_dly);
    bus.imem_gnt = g;
    #1;
    free = !m_pend && (!m_out || rv);
    hit  = 1'b0;
`ifdef KRV_IMEM_LAST_BUF_EN
    hit = free && m_rst_done && m_buf_vld && (npc == m_buf_addr) && !inv;
`endif
    exp_vbus  = m_out && rv && (m_addr == m_pc);
    exp_req   = m_pend || (free && m_rst_done && !hit);
    exp_addr  = m_pend ? m_addr : npc;
    exp_valid = exp_vbus || m_hit;
    exp_data  = exp_vbus ? rd : (m_hit ? m_buf_data : 32'h0);
    s_req   = bus.imem_req;
    s_addr  = bus.imem_addr;
    s_valid = instr_read_data_valid;
    s_data  = instr_read_data;
    chk("imem_req",   {31'b0, s_req},   {31'b0, exp_req});
    chk("imem_addr",  s_addr,           exp_addr);
    chk("data_valid", {31'b0, s_valid}, {31'b0, exp_valid});
    chk("read_data",  s_data,           exp_data);
    @(posedge cpu_clk);
    if (!cpu_rstn) begin
      model_reset();
    end else begin
`ifdef KRV_IMEM_LAST_BUF_EN
      if (inv) m_buf_vld = 1'b0;
      else if (exp_valid) begin
        m_buf_vld  = 1'b1;
        m_buf_addr = m_pc;
        m_buf_data = exp_data;
      end
`endif
      m_hit = hit;
      if (m_pend) begin
        if (g) begin
          m_pend = 1'b0;
          m_out  = 1'b1;
        end
      end else if (free) begin
        m_out = 1'b0;
        if (m_rst_done && !hit) begin
          m_addr = npc;
          if (g) m_out = 1'b1;
          else   m_pend = 1'b1;
        end
      end
      m_pc       = npc;
      m_rst_done = 1'b1;
    end
    if (rv) rs_out = 1'b0;
    else if (rs_out && rs_cnt > 0) rs_cnt--;
    if (s_req && g) begin
      rs_out  = 1'b1;
      rs_addr = s_addr;
      rs_cnt  = rnd ? $urandom_range(0, 2) : lat - 1;
    end
    rs_wait = (s_req && !g) ? rs_wait + 1 : 0;
    cyc++;
  endtask

  initial begin
    logic [31:0] np;
    int          nv;
    boot_addr       = 32'h0000_0080;
    next_pc         = 32'h80;
    imem_buf_inv    = 1'b0;
    cpu_rstn        = 1'b0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    rs_out = 1'b0; rs_cnt = 0; rs_wait = 0; rs_addr = '0;
    rnd = 1'b0; gnt_dly = 0; lat = 1;
    model_reset();

    cycle(32'h80, 1'b0, 1'b0);
    cycle(32'h80, 1'b0, 1'b0);
    chk("rst_valid", {31'b0, s_valid}, 32'd0);
    chk("rst_data",  s_data,           32'h0);

    // reset -> first fetch, then a zero-wait stream
    cycle(32'h80, 1'b0, 1'b1);
    chk("c0_no_req", {31'b0, s_req}, 32'd0);
    cycle(32'h80, 1'b0, 1'b1);
    chk("c1_req",  {31'b0, s_req}, 32'd1);
    chk("c1_addr", s_addr, 32'h80);
    cycle(32'h84, 1'b0, 1'b1);
    chk("c2_valid", {31'b0, s_valid}, 32'd1);
    chk("c2_data",  s_data, memf(32'h80));
    cycle(32'h88, 1'b0, 1'b1);
    chk("stream_84", s_data, memf(32'h84));
    cycle(32'h8C, 1'b0, 1'b1);
    chk("stream_88", s_data, memf(32'h88));

    // wait states: gnt after 2 cycles of request, rvalid 3 cycles after gnt
    gnt_dly = 2; lat = 3; nv = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(32'h100, 1'b0, 1'b1);
      if (i < 3) begin
        chk("ws_req",  {31'b0, s_req}, 32'd1);
        chk("ws_addr", s_addr, 32'h100);
      end
      if (i > 0) nv += int'(s_valid);
    end
    gnt_dly = 0; lat = 1;
    cycle(32'h104, 1'b0, 1'b1);
    nv += int'(s_valid);
    chk("ws_strobe_at_issue_plus5", {31'b0, s_valid}, 32'd1);
    chk("ws_data", s_data, memf(32'h100));
    chk("ws_strobe_count", nv, 32'd1);

    // redirect while in flight
    lat = 2;
    cycle(32'h200, 1'b0, 1'b1);
    chk("rd_issue_addr", s_addr, 32'h200);
    lat = 1;
    cycle(32'h400, 1'b0, 1'b1);
    chk("rd_wait_no_req", {31'b0, s_req}, 32'd0);
    cycle(32'h400, 1'b0, 1'b1);
    chk("rd_stale_dropped", {31'b0, s_valid}, 32'd0);
    chk("rd_reissue_req",   {31'b0, s_req}, 32'd1);
    chk("rd_reissue_addr",  s_addr, 32'h400);
    lat = 3;
    cycle(32'h404, 1'b0, 1'b1);
    chk("rd_deliver_400", s_data, memf(32'h400));

    // reset while waiting; the late rvalid lands after release
    lat = 1;
    cycle(32'h80, 1'b0, 1'b0);
    chk("rw_in_rst_valid", {31'b0, s_valid}, 32'd0);
    cycle(32'h80, 1'b0, 1'b0);
    cycle(32'h80, 1'b0, 1'b1);
    chk("rw_late_rvalid_dropped", {31'b0, s_valid}, 32'd0);
    chk("rw_no_req", {31'b0, s_req}, 32'd0);
    cycle(32'h80, 1'b0, 1'b1);
    chk("rw_restart_addr", s_addr, 32'h80);
    chk("rw_restart_req",  {31'b0, s_req}, 32'd1);
    cycle(32'h300, 1'b0, 1'b1);
    chk("rw_restart_data", s_data, memf(32'h80));

    // last-fetch buffer
    cycle(32'h300, 1'b0, 1'b1);
    cycle(32'h300, 1'b0, 1'b1);
`ifdef KRV_IMEM_LAST_BUF_EN
    chk("buf_hit_no_req", {31'b0, s_req}, 32'd0);
`endif
    cycle(32'h300, 1'b0, 1'b1);
`ifdef KRV_IMEM_LAST_BUF_EN
    chk("buf_valid", {31'b0, s_valid}, 32'd1);
    chk("buf_data",  s_data, memf(32'h300));
`endif
    cycle(32'h300, 1'b1, 1'b1);
`ifdef KRV_IMEM_LAST_BUF_EN
    chk("buf_inv_req",  {31'b0, s_req}, 32'd1);
    chk("buf_inv_addr", s_addr, 32'h300);
`endif
    cycle(32'h304, 1'b0, 1'b1);
    chk("buf_inv_bus_data", s_data, memf(32'h300));

    // randomized traffic
    rnd = 1'b1;
    np  = 32'h80;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) < 7) np = 32'h80 + ((np + 32'd4) & 32'h3C);
      else                          np = 32'h80 + ($urandom & 32'h3C);
      if ($urandom_range(0, 399) == 0) begin
        cycle(np, 1'b0, 1'b0);
        cycle(boot_addr, 1'b0, 1'b0);
        np = boot_addr;
      end
      cycle(np, ($urandom_range(0, 7) == 0), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
